// File: rtl/dnn_pkg.sv
// Shared types, constants and fixed-point helpers for the MLP inference core.
// Activations, weights and biases are signed fixed<18,8> (10 fractional bits).
// Two weight sets live here: a trained set and an all-ones set. The all-ones
// set makes the expected outputs easy to work out by hand.
package dnn_pkg;

  localparam int DATA_W  = 18;
  localparam int FRAC_W  = 10;
  localparam int ACC_W   = 40;
  localparam int LATENCY = 3;
  localparam int N_X     = 2;
  localparam int N_H1    = 4;
  localparam int N_H2    = 4;
  localparam int N_Y     = 1;

  typedef logic signed [DATA_W-1:0] fx_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  localparam fx_t FX_ONE  = 18'sh00400;
  localparam fx_t FX_ZERO = 18'sh00000;
  localparam fx_t FX_MAX  = 18'sh1FFFF;
  localparam fx_t FX_MIN  = 18'sh20000;

  // Trained weight set (raw values, divide by 1024 for the real value).
  localparam fx_t W1_TR [N_H1][N_X] = '{
    '{ 18'sd717, -18'sd410}, '{-18'sd256,  18'sd921},
    '{18'sd1331,  18'sd205}, '{-18'sd614, -18'sd563}};
  localparam fx_t B1_TR [N_H1] = '{18'sd51, -18'sd102, 18'sd0, 18'sd154};
  localparam fx_t W2_TR [N_H2][N_H1] = '{
    '{ 18'sd512, -18'sd307,  18'sd154,  18'sd870},
    '{-18'sd666, 18'sd1126,  18'sd256, -18'sd102},
    '{ 18'sd358,  18'sd358, -18'sd819,  18'sd512},
    '{18'sd1024, -18'sd205,  18'sd461, -18'sd256}};
  localparam fx_t B2_TR [N_H2] = '{-18'sd77, 18'sd128, 18'sd26, -18'sd51};
  localparam fx_t W3_TR [N_Y][N_H2] = '{'{18'sd1229, -18'sd870, 18'sd666, -18'sd410}};
  localparam fx_t B3_TR [N_Y] = '{18'sd102};

  // Unit weight set: every weight 1.0, every bias 0.
  localparam fx_t W1_UN [N_H1][N_X] = '{
    '{FX_ONE, FX_ONE}, '{FX_ONE, FX_ONE}, '{FX_ONE, FX_ONE}, '{FX_ONE, FX_ONE}};
  localparam fx_t B1_UN [N_H1] = '{FX_ZERO, FX_ZERO, FX_ZERO, FX_ZERO};
  localparam fx_t W2_UN [N_H2][N_H1] = '{
    '{FX_ONE, FX_ONE, FX_ONE, FX_ONE}, '{FX_ONE, FX_ONE, FX_ONE, FX_ONE},
    '{FX_ONE, FX_ONE, FX_ONE, FX_ONE}, '{FX_ONE, FX_ONE, FX_ONE, FX_ONE}};
  localparam fx_t B2_UN [N_H2] = '{FX_ZERO, FX_ZERO, FX_ZERO, FX_ZERO};
  localparam fx_t W3_UN [N_Y][N_H2] = '{'{FX_ONE, FX_ONE, FX_ONE, FX_ONE}};
  localparam fx_t B3_UN [N_Y] = '{FX_ZERO};

  function automatic fx_t weight(int layer, bit unit, int o, int i);
    case (layer)
      1:       return unit ? W1_UN[o][i] : W1_TR[o][i];
      2:       return unit ? W2_UN[o][i] : W2_TR[o][i];
      default: return unit ? W3_UN[o][i] : W3_TR[o][i];
    endcase
  endfunction

  function automatic fx_t bias(int layer, bit unit, int o);
    case (layer)
      1:       return unit ? B1_UN[o] : B1_TR[o];
      2:       return unit ? B2_UN[o] : B2_TR[o];
      default: return unit ? B3_UN[o] : B3_TR[o];
    endcase
  endfunction

  // Drop the extra fractional bits (arithmetic shift rounds toward -inf),
  // then clamp to the 18-bit range instead of wrapping.
  function automatic fx_t sat_trunc(acc_t acc);
    acc_t s;
    s = acc >>> FRAC_W;
    if (s > acc_t'(FX_MAX)) return FX_MAX;
    if (s < acc_t'(FX_MIN)) return FX_MIN;
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dnn_dense_layer.sv
// One registered dense layer: out[o] = sat(bias[o] + sum_i w[o][i]*in[i]),
// optionally followed by ReLU. Data registers load only when valid_in is
// high, so the outputs hold their last value during bubbles.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   valid_in   in   data_in carries a sample this cycle
//   data_in    in   N_IN activations
//   valid_out  out  data_out was updated on the last edge
//   data_out   out  N_OUT registered activations
module dnn_dense_layer
  import dnn_pkg::*;
#(
  parameter int N_IN         = 2,
  parameter int N_OUT        = 4,
  parameter int LAYER        = 1,
  parameter bit RELU         = 1'b1,
  parameter bit UNIT_WEIGHTS = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_in,
  input  fx_t  data_in [N_IN],
  output logic valid_out,
  output fx_t  data_out [N_OUT]
);

  fx_t nxt [N_OUT];

  always_comb begin : mac
    acc_t acc;
    fx_t  res;
    for (int o = 0; o < N_OUT; o++) begin
      acc = acc_t'(bias(LAYER, UNIT_WEIGHTS, o)) <<< FRAC_W;
      for (int i = 0; i < N_IN; i++) begin
        acc = acc + acc_t'(data_in[i]) * acc_t'(weight(LAYER, UNIT_WEIGHTS, o, i));
      end
      res = sat_trunc(acc);
      if (RELU && res[DATA_W-1]) res = FX_ZERO;
      nxt[o] = res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      for (int o = 0; o < N_OUT; o++) data_out[o] <= FX_ZERO;
    end else begin
      valid_out <= valid_in;
      if (valid_in) data_out <= nxt;
    end
  end

endmodule

// File: rtl/dnn_inference_core.sv
// Fully pipelined 2-4-4-1 fixed-point MLP, one sample per cycle, three
// register stages from acceptance to the output register.
// Ports:
//   ap_clk            in   clock
//   ap_rst            in   synchronous active-high reset
//   ap_start          in   request to accept a sample
//   input_2_V_ap_vld  in   input word valid
//   input_2_V         in   [17:0]=x0, [35:18]=x1, signed fixed<18,8>
//   ap_done           out  output register updated on the last edge
//   ap_idle           out  no sample in flight and ap_start low
//   ap_ready          out  sample accepted on the coming edge
//   layer7_out_0_V    out  registered network output
module dnn_inference_core
  import dnn_pkg::*;
#(
  parameter int UNIT_WEIGHTS = 0
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  input  logic        input_2_V_ap_vld,
  input  logic [35:0] input_2_V,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic [17:0] layer7_out_0_V
);

  localparam bit UNIT = (UNIT_WEIGHTS != 0);

  fx_t  x  [N_X];
  fx_t  h1 [N_H1];
  fx_t  h2 [N_H2];
  fx_t  y  [N_Y];
  logic v1, v2, v3;

  assign ap_ready = ap_start && input_2_V_ap_vld;
  assign x[0] = input_2_V[17:0];
  assign x[1] = input_2_V[35:18];

  dnn_dense_layer #(.N_IN(N_X), .N_OUT(N_H1), .LAYER(1), .RELU(1'b1), .UNIT_WEIGHTS(UNIT))
    u_l1 (.clk(ap_clk), .rst(ap_rst), .valid_in(ap_ready), .data_in(x),
          .valid_out(v1), .data_out(h1));

  dnn_dense_layer #(.N_IN(N_H1), .N_OUT(N_H2), .LAYER(2), .RELU(1'b1), .UNIT_WEIGHTS(UNIT))
    u_l2 (.clk(ap_clk), .rst(ap_rst), .valid_in(v1), .data_in(h1),
          .valid_out(v2), .data_out(h2));

  // Output layer is linear; its register doubles as the held output.
  dnn_dense_layer #(.N_IN(N_H2), .N_OUT(N_Y), .LAYER(3), .RELU(1'b0), .UNIT_WEIGHTS(UNIT))
    u_l3 (.clk(ap_clk), .rst(ap_rst), .valid_in(v2), .data_in(h2),
          .valid_out(v3), .data_out(y));

  assign ap_done        = v3;
  assign ap_idle        = !ap_start && !(v1 || v2 || v3);
  assign layer7_out_0_V = y[0];

endmodule

// File: tb/tb_dnn_inference_core.sv
// Bench for dnn_inference_core: a unit-weight instance checked against
// hand-computed vectors and sequences, and a trained-weight instance checked
// against a bit-exact model over a random stream with a mid-stream reset.
module tb_dnn_inference_core;
  import dnn_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        vld;
  logic [35:0] data;
  logic        done_u, idle_u, ready_u;
  logic [17:0] out_u;
  logic        done_t, idle_t, ready_t;
  logic [17:0] out_t;

  int errors = 0;
  int checks = 0;

  dnn_inference_core #(.UNIT_WEIGHTS(1)) dut_u (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .input_2_V_ap_vld(vld),
    .input_2_V(data), .ap_done(done_u), .ap_idle(idle_u), .ap_ready(ready_u),
    .layer7_out_0_V(out_u));

  dnn_inference_core #(.UNIT_WEIGHTS(0)) dut_t (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start), .input_2_V_ap_vld(vld),
    .input_2_V(data), .ap_done(done_t), .ap_idle(idle_t), .ap_ready(ready_t),
    .layer7_out_0_V(out_t));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%05h) expected %0d (0x%05h)", name, got, got[17:0], exp, exp[17:0]);
    end
  endtask

  function automatic int s18(logic [17:0] v);
    return int'($signed(v));
  endfunction

  // Bench-side fixed-point arithmetic, written independently of the RTL.
  function automatic longint clamp_fx(longint a);
    longint s;
    s = a >>> 10;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return s;
  endfunction

  function automatic int model(fx_t x0, fx_t x1);
    longint xa [2];
    longint h1 [4];
    longint h2 [4];
    longint acc;
    xa[0] = longint'(x0);
    xa[1] = longint'(x1);
    for (int j = 0; j < 4; j++) begin
      acc = longint'(B1_TR[j]) * 1024;
      for (int i = 0; i < 2; i++) acc += longint'(W1_TR[j][i]) * xa[i];
      h1[j] = clamp_fx(acc);
      if (h1[j] < 0) h1[j] = 0;
    end
    for (int k = 0; k < 4; k++) begin
      acc = longint'(B2_TR[k]) * 1024;
      for (int j = 0; j < 4; j++) acc += longint'(W2_TR[k][j]) * h1[j];
      h2[k] = clamp_fx(acc);
      if (h2[k] < 0) h2[k] = 0;
    end
    acc = longint'(B3_TR[0]) * 1024;
    for (int k = 0; k < 4; k++) acc += longint'(W3_TR[0][k]) * h2[k];
    return int'(clamp_fx(acc));
  endfunction

  task automatic drive(int x0, int x1, bit s, bit v);
    logic [31:0] a;
    logic [31:0] b;
    a = x0;
    b = x1;
    data  = {b[17:0], a[17:0]};
    start = s;
    vld   = v;
  endtask

  typedef struct {
    int x0;
    int x1;
    int y;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic run_vec(int k);
    int lat;
    @(negedge clk);
    drive(vecs[k].x0, vecs[k].x1, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0);
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (done_u) lat = c;
    end
    check($sformatf("vec%0d_latency", k), lat, LATENCY);
    check($sformatf("vec%0d_out", k), s18(out_u), vecs[k].y);
    @(negedge clk);
    check($sformatf("vec%0d_done_pulse", k), int'(done_u), 0);
    check($sformatf("vec%0d_hold", k), s18(out_u), vecs[k].y);
  endtask

  typedef struct {
    bit v;
    int y;
  } stg_t;

  initial begin
    int   s_done [9];
    int   s_out  [9];
    stg_t sh [3];
    int   last_y;
    fx_t  rx0, rx1;

    vecs[0]  = '{1024, 2048, 32'h0C000};
    vecs[1]  = '{-1024, -2048, 0};
    vecs[2]  = '{102400, 102400, 32'h1FFFF};
    vecs[3]  = '{256, 256, 32'h02000};
    vecs[4]  = '{-512, 1024, 32'h02000};
    vecs[5]  = '{3072, -1024, 32'h08000};
    vecs[6]  = '{-102400, -102400, 0};
    vecs[7]  = '{4096, 4096, 32'h1FFFF};
    vecs[8]  = '{512, 256, 32'h03000};
    vecs[9]  = '{1, 0, 32'h00010};
    vecs[10] = '{-1, 0, 0};

    s_done = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
    s_out  = '{0, 0, 0, 32'h02000, 32'h02000, 32'h00800, 32'h00800, 32'h08000, 32'h08000};

    rst = 1'b1;
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out", s18(out_u), 0);
    check("rst_done", int'(done_u), 0);
    check("rst_idle", int'(idle_u), 1);
    check("rst_ready", int'(ready_u), 0);
    check("rst_out_t", s18(out_t), 0);
    start = 1'b1;
    #1;
    check("start_idle", int'(idle_u), 0);
    check("start_novld_ready", int'(ready_u), 0);
    vld = 1'b1;
    #1;
    check("start_vld_ready", int'(ready_u), 1);
    start = 1'b0;
    vld   = 1'b0;
    #1;
    check("idle_again", int'(idle_u), 1);

    for (int k = 0; k < NV; k++) run_vec(k);

    // ap_start high without valid: bubbles only, output held.
    @(negedge clk);
    drive(4096, 4096, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bubble_done", int'(done_u), 0);
      check("bubble_out", s18(out_u), vecs[NV-1].y);
    end

    // Back-to-back stream with a one-cycle valid gap.
    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        check($sformatf("stream_done_t%0d", t), int'(done_u), s_done[t]);
        check($sformatf("stream_out_t%0d", t), s18(out_u), s_out[t]);
      end
      case (t)
        0:       drive(256, 256, 1'b1, 1'b1);
        1:       drive(512, 0, 1'b1, 1'b1);
        2:       drive(0, 128, 1'b1, 1'b1);
        3:       drive(0, 0, 1'b1, 1'b0);
        4:       drive(1024, 1024, 1'b1, 1'b1);
        default: drive(0, 0, 1'b0, 1'b0);
      endcase
    end

    // Reset while two samples are in flight: neither may complete.
    @(negedge clk);
    drive(1024, 2048, 1'b1, 1'b1);
    @(negedge clk);
    drive(256, 256, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int c = 0; c < 6; c++) begin
      check("flush_done", int'(done_u), 0);
      check("flush_out", s18(out_u), 0);
      @(negedge clk);
    end

    // Trained weights: random stream against the model, reset mid-stream.
    for (int i = 0; i < 3; i++) sh[i] = '{1'b0, 0};
    last_y = 0;
    for (int i = 0; i < 10000; i++) begin
      logic [31:0] r;
      int          sv;
      @(negedge clk);
      check("rnd_done", int'(done_t), int'(sh[2].v));
      if (sh[2].v) last_y = sh[2].y;
      check("rnd_out", s18(out_t), last_y);
      sh[2] = sh[1];
      sh[1] = sh[0];
      if (i == 5000) begin
        rst = 1'b1;
        drive(0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) sh[j] = '{1'b0, 0};
        last_y = 0;
      end else begin
        rst = 1'b0;
        r = $urandom;
        if (r[1:0] == 2'b00) begin
          rx0 = r[17:0];
          r   = $urandom;
          rx1 = r[17:0];
        end else begin
          sv  = int'($urandom_range(0, 8191)) - 4096;
          rx0 = sv[17:0];
          sv  = int'($urandom_range(0, 8191)) - 4096;
          rx1 = sv[17:0];
        end
        drive(int'(rx0), int'(rx1), $urandom_range(0, 15) != 0, $urandom_range(0, 4) != 0);
        sh[0].v = start && vld;
        sh[0].y = model(rx0, rx1);
        #1;
        check("rnd_ready", int'(ready_t), int'(start && vld));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
